// File: rtl/sa_tile_sched_pkg.sv
// Shared definitions for the systolic-array tile scheduler.
// Provides the scheduler state encoding and the default tile strides
// derived from the default 4x4 array geometry.
package sa_tile_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_ADVANCE,
    S_FINISH,
    S_X
  } sched_state_e;

  localparam int DEFAULT_NUM_ROWS   = 4;
  localparam int DEFAULT_NUM_COLS   = 4;
  localparam int DEFAULT_IN_STRIDE  = DEFAULT_NUM_COLS + DEFAULT_NUM_ROWS - 1;
  localparam int DEFAULT_WT_STRIDE  = DEFAULT_NUM_ROWS;
  localparam int DEFAULT_OUT_STRIDE = DEFAULT_NUM_COLS + 1;

endpackage

// File: rtl/sa_tile_sched_if.sv
// Bus bundle between the host/CSR layer, the array controller and the
// tile scheduler. Signal names keep their i_/o_ prefixes as seen from
// the scheduler.
//   master : host + array-controller side (drives i_*, observes o_*)
//   slave  : scheduler side (observes i_*, drives o_*)
interface sa_tile_sched_if #(
  parameter int TILE_CNT_WIDTH = 4,
  parameter int ADDR_WIDTH     = 10
);
  logic                      i_cfg_valid;
  logic                      o_cfg_ready;
  logic [TILE_CNT_WIDTH-1:0] i_cfg_tiles_m;
  logic [TILE_CNT_WIDTH-1:0] i_cfg_tiles_n;
  logic [ADDR_WIDTH-1:0]     i_cfg_in_base;
  logic [ADDR_WIDTH-1:0]     i_cfg_wt_base;
  logic [ADDR_WIDTH-1:0]     i_cfg_out_base;
  logic                      i_abort;
  logic                      o_arr_start;
  logic                      i_arr_done;
  logic [ADDR_WIDTH-1:0]     o_in_base;
  logic [ADDR_WIDTH-1:0]     o_wt_base;
  logic [ADDR_WIDTH-1:0]     o_out_base;
  logic [TILE_CNT_WIDTH-1:0] o_tile_m;
  logic [TILE_CNT_WIDTH-1:0] o_tile_n;
  logic                      o_busy;
  logic                      o_job_done;
  logic                      o_error;

  modport master (
    output i_cfg_valid, i_cfg_tiles_m, i_cfg_tiles_n, i_cfg_in_base,
           i_cfg_wt_base, i_cfg_out_base, i_abort, i_arr_done,
    input  o_cfg_ready, o_arr_start, o_in_base, o_wt_base, o_out_base,
           o_tile_m, o_tile_n, o_busy, o_job_done, o_error
  );

  modport slave (
    input  i_cfg_valid, i_cfg_tiles_m, i_cfg_tiles_n, i_cfg_in_base,
           i_cfg_wt_base, i_cfg_out_base, i_abort, i_arr_done,
    output o_cfg_ready, o_arr_start, o_in_base, o_wt_base, o_out_base,
           o_tile_m, o_tile_n, o_busy, o_job_done, o_error
  );
endinterface

// File: rtl/sa_tile_addr_gen.sv
// Tile index counters and base-address accumulators.
// load    : capture a new job config and point at tile (0,0).
// advance : step to the next tile, m inner, n outer. Only pulsed when
//           the current tile is not the last one.
// last_tile is high while the indices point at the final tile.
// All address arithmetic wraps modulo 2^ADDR_WIDTH.
module sa_tile_addr_gen #(
  parameter int TILE_CNT_WIDTH = 4,
  parameter int ADDR_WIDTH     = 10,
  parameter int IN_STRIDE      = 7,
  parameter int WT_STRIDE      = 4,
  parameter int OUT_STRIDE     = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      advance,
  input  logic [TILE_CNT_WIDTH-1:0] cfg_tiles_m,
  input  logic [TILE_CNT_WIDTH-1:0] cfg_tiles_n,
  input  logic [ADDR_WIDTH-1:0]     cfg_in_base,
  input  logic [ADDR_WIDTH-1:0]     cfg_wt_base,
  input  logic [ADDR_WIDTH-1:0]     cfg_out_base,
  output logic [TILE_CNT_WIDTH-1:0] tile_m,
  output logic [TILE_CNT_WIDTH-1:0] tile_n,
  output logic [ADDR_WIDTH-1:0]     in_base,
  output logic [ADDR_WIDTH-1:0]     wt_base,
  output logic [ADDR_WIDTH-1:0]     out_base,
  output logic                      last_tile
);

  localparam logic [ADDR_WIDTH-1:0] IN_STEP  = ADDR_WIDTH'(IN_STRIDE);
  localparam logic [ADDR_WIDTH-1:0] WT_STEP  = ADDR_WIDTH'(WT_STRIDE);
  localparam logic [ADDR_WIDTH-1:0] OUT_STEP = ADDR_WIDTH'(OUT_STRIDE);

  logic [TILE_CNT_WIDTH-1:0] tiles_m;
  logic [TILE_CNT_WIDTH-1:0] tiles_n;
  logic [ADDR_WIDTH-1:0]     in_base_start;

  // Indices never exceed the latched limits, so the +1 cannot overflow
  // even when a limit is all-ones.
  assign last_tile = (tile_m == tiles_m) && (tile_n == tiles_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tiles_m       <= '0;
      tiles_n       <= '0;
      in_base_start <= '0;
      tile_m        <= '0;
      tile_n        <= '0;
      in_base       <= '0;
      wt_base       <= '0;
      out_base      <= '0;
    end else if (load) begin
      tiles_m       <= cfg_tiles_m;
      tiles_n       <= cfg_tiles_n;
      in_base_start <= cfg_in_base;
      tile_m        <= '0;
      tile_n        <= '0;
      in_base       <= cfg_in_base;
      wt_base       <= cfg_wt_base;
      out_base      <= cfg_out_base;
    end else if (advance) begin
      if (tile_m < tiles_m) begin
        tile_m  <= tile_m + 1'b1;
        in_base <= in_base + IN_STEP;
      end else if (tile_n < tiles_n) begin
        // Wrap the inner dimension back to the first input tile.
        tile_m  <= '0;
        in_base <= in_base_start;
        tile_n  <= tile_n + 1'b1;
        wt_base <= wt_base + WT_STEP;
      end
      out_base <= out_base + OUT_STEP;
    end
  end

endmodule

// File: rtl/sa_tile_sched.sv
// Job-level scheduler above the systolic array controller. A job is
// split into (tiles_m+1)*(tiles_n+1) array passes; for each pass the
// tile bases are presented, o_arr_start is pulsed and the scheduler
// waits for the controller's done level to fall and rise again.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sa_tile_sched_if.slave (cfg handshake, abort, array
//                start/done, tile bases/indices, busy/job_done/error)
// Optional feature: define SA_TILE_SCHED_TIMEOUT_EN to add a watchdog on
// the done waits that aborts the job and raises a sticky o_error.
module sa_tile_sched
  import sa_tile_sched_pkg::*;
#(
  parameter int NUM_ROWS       = DEFAULT_NUM_ROWS,
  parameter int NUM_COLS       = DEFAULT_NUM_COLS,
  parameter int TILE_CNT_WIDTH = 4,
  parameter int ADDR_WIDTH     = 10,
  parameter int IN_STRIDE      = NUM_COLS + NUM_ROWS - 1,
  parameter int WT_STRIDE      = NUM_ROWS,
  parameter int OUT_STRIDE     = NUM_COLS + 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  sa_tile_sched_if.slave bus
);

  sched_state_e state;
  logic         cfg_ready;
  logic         arr_start;
  logic         busy;
  logic         job_done;
  logic         load;
  logic         advance;
  logic         last_tile;

  logic [TILE_CNT_WIDTH-1:0] tile_m;
  logic [TILE_CNT_WIDTH-1:0] tile_n;
  logic [ADDR_WIDTH-1:0]     in_base;
  logic [ADDR_WIDTH-1:0]     wt_base;
  logic [ADDR_WIDTH-1:0]     out_base;

  // cfg_ready is only high in IDLE, so this is the accepted handshake.
  assign load    = (state == S_IDLE) && bus.i_cfg_valid;
  // Abort freezes the indices, and the final tile never steps them.
  assign advance = (state == S_ADVANCE) && !bus.i_abort && !last_tile;

  sa_tile_addr_gen #(
    .TILE_CNT_WIDTH (TILE_CNT_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .IN_STRIDE      (IN_STRIDE),
    .WT_STRIDE      (WT_STRIDE),
    .OUT_STRIDE     (OUT_STRIDE)
  ) addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .advance      (advance),
    .cfg_tiles_m  (bus.i_cfg_tiles_m),
    .cfg_tiles_n  (bus.i_cfg_tiles_n),
    .cfg_in_base  (bus.i_cfg_in_base),
    .cfg_wt_base  (bus.i_cfg_wt_base),
    .cfg_out_base (bus.i_cfg_out_base),
    .tile_m       (tile_m),
    .tile_n       (tile_n),
    .in_base      (in_base),
    .wt_base      (wt_base),
    .out_base     (out_base),
    .last_tile    (last_tile)
  );

`ifdef SA_TILE_SCHED_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic                 error;
`endif

  // Control FSM. Every output is registered and is set on the transition
  // into the state that owns it, so start/job_done are exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cfg_ready <= 1'b1;
      arr_start <= 1'b0;
      busy      <= 1'b0;
      job_done  <= 1'b0;
`ifdef SA_TILE_SCHED_TIMEOUT_EN
      wait_cnt  <= '0;
      error     <= 1'b0;
`endif
    end else begin
      arr_start <= 1'b0;
      job_done  <= 1'b0;
      if (state != S_IDLE && bus.i_abort) begin
        state     <= S_IDLE;
        cfg_ready <= 1'b1;
        busy      <= 1'b0;
      end
`ifdef SA_TILE_SCHED_TIMEOUT_EN
      else if ((state == S_WAIT_LOW || state == S_WAIT_HIGH) &&
               wait_cnt == CNT_LAST) begin
        state     <= S_IDLE;
        cfg_ready <= 1'b1;
        busy      <= 1'b0;
        error     <= 1'b1;
      end
`endif
      else begin
        case (state)
          S_IDLE: begin
            if (bus.i_cfg_valid) begin
              state     <= S_ISSUE;
              arr_start <= 1'b1;
              cfg_ready <= 1'b0;
              busy      <= 1'b1;
`ifdef SA_TILE_SCHED_TIMEOUT_EN
              error     <= 1'b0;
`endif
            end
          end
          S_ISSUE: begin
            state <= S_WAIT_LOW;
`ifdef SA_TILE_SCHED_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
          // Done is still high from the previous pass for a couple of
          // cycles after start; only its fall arms the completion wait.
          S_WAIT_LOW: begin
            if (!bus.i_arr_done) state <= S_WAIT_HIGH;
`ifdef SA_TILE_SCHED_TIMEOUT_EN
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
          S_WAIT_HIGH: begin
            if (bus.i_arr_done) state <= S_ADVANCE;
`ifdef SA_TILE_SCHED_TIMEOUT_EN
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
          S_ADVANCE: begin
            if (last_tile) begin
              state    <= S_FINISH;
              job_done <= 1'b1;
            end else begin
              state     <= S_ISSUE;
              arr_start <= 1'b1;
            end
          end
          S_FINISH: begin
            state     <= S_IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
          end
          default: begin
            state     <= S_IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_cfg_ready = cfg_ready;
  assign bus.o_arr_start = arr_start;
  assign bus.o_busy      = busy;
  assign bus.o_job_done  = job_done;
  assign bus.o_in_base   = in_base;
  assign bus.o_wt_base   = wt_base;
  assign bus.o_out_base  = out_base;
  assign bus.o_tile_m    = tile_m;
  assign bus.o_tile_n    = tile_n;
`ifdef SA_TILE_SCHED_TIMEOUT_EN
  assign bus.o_error     = error;
`else
  assign bus.o_error     = 1'b0;
`endif

endmodule
